pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline. Drives enables and flushes of
//   PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers.
//   Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
//   Includes a memory-timeout error trap and a saturating stall-cycle counter.
// PARAMETERS
//   REG_W    5    register-index width
//   CNT_W    16   stall_count width
//   TIMEOUT  255  max consecutive MEMWAIT cycles before entering ERR (1..255)
// PORTS
//   clk            in   1      clock, rising edge
//   rst            in   1      synchronous reset, active-high
//   id_rs          in   REG_W  source reg 1 of instr in ID
//   id_rt          in   REG_W  source reg 2 of instr in ID
//   id_uses_rt     in   1      ID instr reads id_rt
//   ex_rd          in   REG_W  dest reg of instr in EX
//   ex_mem_read    in   1      instr in EX is a load
//   ex_branch_taken in  1      branch in EX resolved taken
//   mem_req        in   1      instr in MEM accesses data memory
//   mem_ready      in   1      data memory completes access this cycle
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en  out 1 each: register load enables
//   ifid_flush     out  1      IF/ID loads NOP
//   idex_flush     out  1      ID/EX loads bubble (all controls 0)
//   memwb_bubble   out  1      MEM/WB loads bubble
//   state          out  2      FSM state: RUN=0, MEMWAIT=1, ERR=2
//   err            out  1      memory timeout trap, sticky
//   stall_count    out  CNT_W  cycles with pc_en=0, saturating
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=RUN, wait_cnt=0, branch_pend=0, err=0, stall_count=0.
//     While rst=1, all enables, flushes and memwb_bubble are forced to 0.
//   - Outputs are combinational from registered state plus current inputs; zero latency.
//   - hazard = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//   - RUN, priority highest first:
//     1. mem_req & !mem_ready:
//        - All enables 0, memwb_bubble=1.
//        - branch_pend <= ex_branch_taken; wait_cnt <= 1; next=MEMWAIT.
//     2. ex_branch_taken:
//        - All enables 1, ifid_flush=1, idex_flush=1.
//        - Load-use is ignored because the dependent instruction is flushed.
//     3. hazard:
//        - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
//        - Single-cycle bubble; no state change.
//     4. Otherwise: all enables 1, no flush.
//   - MEMWAIT:
//     - mem_ready=0:
//       - All enables 0, memwb_bubble=1.
//       - branch_pend <= branch_pend | ex_branch_taken.
//       - If wait_cnt==TIMEOUT: next=ERR, err<=1. Else wait_cnt++.
//     - mem_ready=1: this cycle behaves as RUN rules 2-4, using
//       branch = ex_branch_taken | branch_pend. Then branch_pend<=0, wait_cnt<=0, next=RUN.
//   - ERR: all enables 0, memwb_bubble=1, err=1. Only rst exits.
//   - stall_count increments in every non-reset cycle with pc_en=0 (including ERR).
//     It holds at 2^CNT_W-1.
//   - Reset mid-MEMWAIT aborts the wait: branch_pend is dropped and the next cycle is RUN.
//   - Flush and enable asserted together means the register loads NOP/bubble.
// TESTING
//   - Load r5 in EX (ex_rd=5, ex_mem_read=1), id_rs=5:
//     -> one cycle pc_en=0, ifid_en=0, idex_flush=1.
//     -> Next cycle with ex_mem_read=0: all en=1. stall_count=1.
//   - ex_branch_taken=1 together with hazard:
//     -> ifid_flush=1, idex_flush=1, pc_en=1. No stall; stall_count unchanged.
//   - mem_req=1, mem_ready low for 3 cycles then high:
//     -> state=MEMWAIT for 3 cycles with all en=0 and memwb_bubble=1.
//     -> On the 4th cycle, en=1 and state returns to RUN. stall_count=3.
//   - ex_branch_taken pulsed during 2nd MEMWAIT cycle:
//     -> on the mem_ready cycle ifid_flush=1 and idex_flush=1, then branch_pend=0.
//   - TIMEOUT=4, mem_ready held 0:
//     -> err=1 and state=ERR after 5 stall cycles. ERR persists until rst.
//   - rst asserted during MEMWAIT:
//     -> next cycle state=RUN, err=0, stall_count=0, and no pending flush is applied.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The master side (datapath) supplies the ID/EX/MEM status; the slave side
// (pipeline_hazard_ctrl) returns register enables, flushes and status.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  // Pipeline status
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  // Pipeline register control
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;

  // Status
  logic [1:0]       state;
  logic             err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_bubble, state, err, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_bubble, state, err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory wait states with a timeout trap, and a saturating count of
// cycles in which the PC was held. Register widths come from the interface.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255  // max consecutive MEMWAIT cycles before ERR (1..255)
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       branch_pend_reg, branch_pend_next;
  logic       err_next;

  logic hazard;
  logic branch;
  logic mem_stall;
  logic run_rules;

  // Load-use: a load in EX writes a register the ID instruction reads (r0 never hazards).
  assign hazard = hz.ex_mem_read && (hz.ex_rd != '0) &&
                  ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  // A branch taken while memory was stalled is remembered and applied on release.
  assign branch = hz.ex_branch_taken || ((state_reg == MEMWAIT) && branch_pend_reg);

  // Whole pipeline frozen this cycle (memory wait, fresh miss, or trapped).
  assign mem_stall = (state_reg == RUN)     ? (hz.mem_req && !hz.mem_ready) :
                     (state_reg == MEMWAIT) ? !hz.mem_ready : 1'b1;

  // Branch/hazard/normal rules apply only when memory is not holding the pipeline.
  assign run_rules = !mem_stall;

  assign hz.state = state_reg;

  // State, wait bookkeeping, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      branch_pend_reg <= 1'b0;
      hz.err          <= 1'b0;
      hz.stall_count  <= '0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      branch_pend_reg <= branch_pend_next;
      hz.err          <= err_next;
      if (!hz.pc_en && (hz.stall_count != '1)) begin
        hz.stall_count <= hz.stall_count + 1'b1;
      end
    end
  end

  // Next-state: enter MEMWAIT on a miss, count wait cycles, trap on timeout.
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    branch_pend_next = branch_pend_reg;
    err_next         = hz.err;
    case (state_reg)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          branch_pend_next = hz.ex_branch_taken;
          wait_cnt_next    = 8'd1;
          state_next       = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (!hz.mem_ready) begin
          branch_pend_next = branch_pend_reg || hz.ex_branch_taken;
          if (wait_cnt_reg == TIMEOUT_V) begin
            state_next = ERR;
            err_next   = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end else begin
          branch_pend_next = 1'b0;
          wait_cnt_next    = 8'd0;
          state_next       = RUN;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Outputs: freeze on memory stall, else branch flush beats load-use bubble.
  always_comb begin
    hz.pc_en        = 1'b0;
    hz.ifid_en      = 1'b0;
    hz.idex_en      = 1'b0;
    hz.exmem_en     = 1'b0;
    hz.memwb_en     = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.idex_flush   = 1'b0;
    hz.memwb_bubble = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        hz.memwb_bubble = 1'b1;
      end else if (run_rules) begin
        hz.idex_en  = 1'b1;
        hz.exmem_en = 1'b1;
        hz.memwb_en = 1'b1;
        if (branch) begin
          hz.pc_en      = 1'b1;
          hz.ifid_en    = 1'b1;
          hz.ifid_flush = 1'b1;
          hz.idex_flush = 1'b1;
        end else if (hazard) begin
          hz.idex_flush = 1'b1;
        end else begin
          hz.pc_en   = 1'b1;
          hz.ifid_en = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: each stimulus cycle pushes its hand-computed expected
// outputs; a monitor on the falling edge pops and compares one entry per cycle.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz ();

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    string       name;
    logic [26:0] vec;  // {pc,ifid,idex,exmem,memwb, ifid_flush,idex_flush,bubble, state, err, stall_count}
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Enable patterns {pc_en, ifid_en, idex_en, exmem_en, memwb_en}
  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] HAZ  = 5'b00111;
  localparam logic [4:0] NONE = 5'b00000;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic apply(input string name, input logic r,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic mq, input logic my,
                       input logic [4:0] en, input logic ff, input logic fx,
                       input logic bb, input logic [1:0] st, input logic er,
                       input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    hz.id_rs           = rs;
    hz.id_rt           = rt;
    hz.id_uses_rt      = ut;
    hz.ex_rd           = rd;
    hz.ex_mem_read     = mr;
    hz.ex_branch_taken = br;
    hz.mem_req         = mq;
    hz.mem_ready       = my;
    e.name = name;
    e.vec  = {en, ff, fx, bb, st, er, cnt[15:0]};
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so compare one queued entry per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [26:0] act;
      e   = exp_q.pop_front();
      act = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
             hz.ifid_flush, hz.idex_flush, hz.memwb_bubble,
             hz.state, hz.err, hz.stall_count};
      tests++;
      if (act !== e.vec) begin
        failed++;
        $display("[TB] FAIL %s: got en=%b fl=%b bub=%b st=%0d err=%b cnt=%0d, expected en=%b fl=%b bub=%b st=%0d err=%b cnt=%0d",
                 e.name, act[26:22], act[21:20], act[19], act[18:17], act[16], act[15:0],
                 e.vec[26:22], e.vec[21:20], e.vec[19], e.vec[18:17], e.vec[16], e.vec[15:0]);
      end else begin
        $display("[TB] %s ok: en=%b fl=%b bub=%b st=%0d err=%b cnt=%0d",
                 e.name, act[26:22], act[21:20], act[19], act[18:17], act[16], act[15:0]);
      end
    end
  end

  initial begin
    int waited;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.ex_rd = '0;
    hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    //     name            rst rs  rt  ut rd  mr br mq my  en    iff idf bub st er cnt
    apply("reset",         1, 0,  0,  0, 0,  0, 0, 0, 0, NONE, 0, 0, 0, 0, 0, 0);
    apply("idle",          0, 0,  0,  0, 0,  0, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 0);
    apply("loaduse_rs",    0, 5,  0,  0, 5,  1, 0, 0, 0, HAZ,  0, 1, 0, 0, 0, 0);
    apply("after_load",    0, 5,  0,  0, 5,  0, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 1);
    apply("loaduse_rt",    0, 3,  7,  1, 7,  1, 0, 0, 0, HAZ,  0, 1, 0, 0, 0, 1);
    apply("rt_unused",     0, 3,  7,  0, 7,  1, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 2);
    apply("load_r0",       0, 0,  0,  0, 0,  1, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 2);
    apply("branch_hazard", 0, 5,  0,  0, 5,  1, 1, 0, 0, ALL,  1, 1, 0, 0, 0, 2);
    // Miss with three low cycles, branch pulsed in the second MEMWAIT cycle
    apply("miss_start",    0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 0, 0, 2);
    apply("wait_1",        0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 1, 0, 3);
    apply("wait_2_branch", 0, 0,  0,  0, 0,  0, 1, 1, 0, NONE, 0, 0, 1, 1, 0, 4);
    apply("ready_pend",    0, 0,  0,  0, 0,  0, 0, 1, 1, ALL,  1, 1, 0, 1, 0, 5);
    apply("pend_cleared",  0, 0,  0,  0, 0,  0, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 5);
    // Load-use resolved on the memory-release cycle
    apply("miss2",         0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 0, 0, 5);
    apply("ready_hazard",  0, 4,  0,  0, 4,  1, 0, 1, 1, HAZ,  0, 1, 0, 1, 0, 6);
    apply("idle2",         0, 0,  0,  0, 0,  0, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 7);
    // Branch captured on the miss cycle itself
    apply("miss_branch",   0, 0,  0,  0, 0,  0, 1, 1, 0, NONE, 0, 0, 1, 0, 0, 7);
    apply("ready_flush",   0, 0,  0,  0, 0,  0, 0, 1, 1, ALL,  1, 1, 0, 1, 0, 8);
    // Timeout (TIMEOUT=4): ERR after five stall cycles
    apply("to_miss",       0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 0, 0, 8);
    apply("to_wait1",      0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 1, 0, 9);
    apply("to_wait2",      0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 1, 0, 10);
    apply("to_wait3",      0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 1, 0, 11);
    apply("to_wait4",      0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 1, 0, 12);
    apply("err_ready",     0, 0,  0,  0, 0,  0, 0, 1, 1, NONE, 0, 0, 1, 2, 1, 13);
    apply("err_idle",      0, 0,  0,  0, 0,  0, 0, 0, 0, NONE, 0, 0, 1, 2, 1, 14);
    apply("err_reset",     1, 0,  0,  0, 0,  0, 0, 0, 0, NONE, 0, 0, 0, 2, 1, 15);
    apply("post_reset",    0, 0,  0,  0, 0,  0, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 0);
    // Reset in the middle of MEMWAIT drops the pending branch
    apply("rm_miss_br",    0, 0,  0,  0, 0,  0, 1, 1, 0, NONE, 0, 0, 1, 0, 0, 0);
    apply("rm_wait",       0, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 1, 1, 0, 1);
    apply("rm_reset",      1, 0,  0,  0, 0,  0, 0, 1, 0, NONE, 0, 0, 0, 1, 0, 2);
    apply("rm_no_flush",   0, 0,  0,  0, 0,  0, 0, 1, 1, ALL,  0, 0, 0, 0, 0, 0);
    apply("rm_idle",       0, 0,  0,  0, 0,  0, 0, 0, 0, ALL,  0, 0, 0, 0, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      failed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
